// File: rtl/pulse_pkg.sv
// Shared types and widths for the pulse-descriptor playback path.
package pulse_pkg;

   localparam int unsigned PULSE_REG_TSTART_W = 32;
   localparam int unsigned PULSE_MEM_ADDR_W   = 10;
   localparam int unsigned PULSE_SAMPLE_W     = 16;
   // Pulse memory words are {last, sample}; the flag sits just above the sample.
   localparam int unsigned PULSE_LAST_BIT     = PULSE_SAMPLE_W;

   typedef struct packed {
      logic [PULSE_REG_TSTART_W-1:0] delay;
      logic [PULSE_MEM_ADDR_W-1:0]   pulse_mem_addr;
   } pulse_descriptor_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FETCH = 2'd2,
      ST_PLAY  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/pulse_delay_timer.sv
// Pre-playback countdown; expire_o is high in the final WAIT cycle.
module pulse_delay_timer #(
   parameter int unsigned DELAY_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic [DELAY_W-1:0] delay_i,
   input  logic               en_i,
   input  logic               clear_i,
   output logic               expire_o
);

   logic [DELAY_W-1:0] cnt_q, cnt_d;
   logic               exp_q, exp_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         exp_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         exp_q <= exp_d;
      end
   end

   // expire is precomputed one cycle ahead so it is registered alongside cnt_q==1.
   always_comb begin
      cnt_d = cnt_q;
      exp_d = exp_q;
      if (clear_i) begin
         cnt_d = '0;
         exp_d = 1'b0;
      end else if (load_i) begin
         cnt_d = delay_i;
         exp_d = (delay_i == DELAY_W'(1));
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - DELAY_W'(1);
         exp_d = (cnt_q == DELAY_W'(2));
      end
   end

   assign expire_o = exp_q;

endmodule

// File: rtl/pulse_sequencer.sv
// Descriptor-driven pulse playback: wait out the delay, then stream samples
// from pulse memory until the last marker, MAX_LEN, or flush.
module pulse_sequencer
   import pulse_pkg::*;
#(
   parameter int unsigned DELAY_W  = PULSE_REG_TSTART_W,
   parameter int unsigned ADDR_W   = PULSE_MEM_ADDR_W,
   parameter int unsigned SAMPLE_W = PULSE_SAMPLE_W,
   parameter int unsigned MAX_LEN  = 256
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                desc_valid,
   output logic                desc_ready,
   input  logic [DELAY_W-1:0]  desc_delay,
   input  logic [ADDR_W-1:0]   desc_addr,
   input  logic                flush,
   output logic                mem_ren,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic [SAMPLE_W:0]   mem_rdata,
   output logic                sample_valid,
   output logic [SAMPLE_W-1:0] sample_data,
   output logic                pulse_start,
   output logic                pulse_done,
   output logic                busy,
   output logic                err_len
);

   localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_inc_c;
   logic              timer_load_c;
   logic              timer_expire_c;

   pulse_delay_timer #(.DELAY_W(DELAY_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load_i   (timer_load_c),
      .delay_i  (desc_delay),
      .en_i     (state_q == ST_WAIT),
      .clear_i  (flush),
      .expire_o (timer_expire_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      desc_ready   = 1'b0;
      mem_ren      = 1'b0;
      mem_addr     = '0;
      sample_valid = 1'b0;
      sample_data  = '0;
      pulse_start  = 1'b0;
      pulse_done   = 1'b0;
      timer_load_c = 1'b0;
      cnt_inc_c    = cnt_q + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            desc_ready = !flush;
            if (desc_valid && !flush) begin
               addr_d       = desc_addr;
               cnt_d        = '0;
               timer_load_c = 1'b1;
               state_d      = (desc_delay == '0) ? ST_FETCH : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (flush)               state_d = ST_IDLE;
            else if (timer_expire_c) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               mem_ren  = 1'b1;
               mem_addr = addr_q;
               state_d  = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               sample_valid = 1'b1;
               sample_data  = mem_rdata[SAMPLE_W-1:0];
               pulse_start  = (cnt_q == '0);
               cnt_d        = cnt_inc_c;
               if (mem_rdata[SAMPLE_W]) begin
                  pulse_done = 1'b1;
                  state_d    = ST_IDLE;
               end else if (cnt_inc_c >= CNT_W'(MAX_LEN)) begin
                  // Runaway pulse: force termination and flag it until reset.
                  pulse_done = 1'b1;
                  err_d      = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  mem_ren  = 1'b1;
                  mem_addr = addr_q + ADDR_W'(1);
                  addr_d   = addr_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy    = (state_q != ST_IDLE);
   assign err_len = err_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer with a behavioural pulse memory.
module tb_pulse_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        desc_valid = 1'b0;
   logic        desc_ready;
   logic [31:0] desc_delay = '0;
   logic [9:0]  desc_addr = '0;
   logic        flush = 1'b0;
   logic        mem_ren;
   logic [9:0]  mem_addr;
   logic [16:0] mem_rdata = '0;
   logic        sample_valid;
   logic [15:0] sample_data;
   logic        pulse_start;
   logic        pulse_done;
   logic        busy;
   logic        err_len;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct {
      logic [15:0] data;
      logic        st;
      logic        dn;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [9:0]  exp_addr[$];
   logic [16:0] mem [1024];

   pulse_sequencer #(.MAX_LEN(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .desc_valid   (desc_valid),
      .desc_ready   (desc_ready),
      .desc_delay   (desc_delay),
      .desc_addr    (desc_addr),
      .flush        (flush),
      .mem_ren      (mem_ren),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .pulse_start  (pulse_start),
      .pulse_done   (pulse_done),
      .busy         (busy),
      .err_len      (err_len)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_s(input logic [15:0] d, input logic st, input logic dn, input int c);
      exp_t e;
      e.data = d; e.st = st; e.dn = dn; e.cyc = c;
      exp_q.push_back(e);
   endtask

   // Caller sits just after a posedge; returns cyc value of the accepting edge.
   task automatic send(input logic [31:0] d, input logic [9:0] a, output int acc);
      int n;
      n = 0;
      acc = -1;
      desc_delay = d;
      desc_addr  = a;
      desc_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (desc_ready) break;
         n++;
         if (n > 300) begin
            chk("accept_timeout", 32'(desc_ready), 32'd1);
            desc_valid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      acc = cyc;
      desc_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || exp_addr.size() != 0) && n < 100) begin
         @(posedge clk); n++;
      end
      #1;
      chk("drain_pending", 32'(exp_q.size() + exp_addr.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard whenever the DUT reads memory or emits a sample.
   always @(negedge clk) begin
      exp_t e;
      logic [9:0] ea;
      if (!reset) begin
         if (mem_ren) begin
            if (exp_addr.size() == 0) chk("mem_ren_unexpected", 32'(mem_ren), 32'd0);
            else begin
               ea = exp_addr.pop_front();
               chk("mem_addr", 32'(mem_addr), 32'(ea));
            end
         end
         if (sample_valid) begin
            if (exp_q.size() == 0) chk("sample_valid_unexpected", 32'(sample_valid), 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("sample_data", 32'(sample_data), 32'(e.data));
               chk("pulse_start", 32'(pulse_start), 32'(e.st));
               chk("pulse_done", 32'(pulse_done), 32'(e.dn));
               chk("sample_cycle", 32'(cyc), 32'(e.cyc));
            end
         end else if (pulse_start || pulse_done) begin
            chk("strobe_without_sample", 32'({pulse_start, pulse_done}), 32'd0);
         end
      end
   end

   initial begin
      int acc, acc2;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[10'h010] = 17'h00AAA; mem[10'h011] = 17'h00BBB; mem[10'h012] = 17'h10CCC;
      mem[10'h020] = 17'h01111; mem[10'h021] = 17'h12222;
      mem[10'h030] = 17'h10333;
      mem[10'h040] = 17'h00444; mem[10'h041] = 17'h10555;
      mem[10'h3FF] = 17'h00F01; mem[10'h000] = 17'h00F02; mem[10'h001] = 17'h10F03;
      for (int i = 0; i < 5; i++) mem[10'h100 + i] = 17'(16'h0101 + i);
      for (int i = 0; i < 4; i++) mem[10'h200 + i] = 17'(16'h0201 + i);
      mem[10'h204] = 17'h10205;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_desc_ready", 32'(desc_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err_len", 32'(err_len), 32'd0);
      chk("rst_outputs", 32'({sample_valid, pulse_start, pulse_done, mem_ren}), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Three-word pulse, no delay.
      send(32'd0, 10'h010, acc);
      exp_addr.push_back(10'h010); exp_addr.push_back(10'h011); exp_addr.push_back(10'h012);
      push_s(16'h0AAA, 1'b1, 1'b0, acc + 1);
      push_s(16'h0BBB, 1'b0, 1'b0, acc + 2);
      push_s(16'h0CCC, 1'b0, 1'b1, acc + 3);
      drain();

      // Delay of 5: first sample after the 6th edge; ready low until after the last sample.
      send(32'd5, 10'h020, acc);
      exp_addr.push_back(10'h020); exp_addr.push_back(10'h021);
      push_s(16'h1111, 1'b1, 1'b0, acc + 6);
      push_s(16'h2222, 1'b0, 1'b1, acc + 7);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("wait_desc_ready_low", 32'(desc_ready), 32'd0);
      end
      @(negedge clk);
      chk("post_pulse_desc_ready", 32'(desc_ready), 32'd1);
      chk("post_pulse_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      drain();

      // Back-to-back: length-1 pulse then length-2 pulse.
      send(32'd0, 10'h030, acc);
      exp_addr.push_back(10'h030);
      push_s(16'h0333, 1'b1, 1'b1, acc + 1);
      send(32'd0, 10'h040, acc2);
      chk("b2b_accept_cycle", 32'(acc2), 32'(acc + 3));
      exp_addr.push_back(10'h040); exp_addr.push_back(10'h041);
      push_s(16'h0444, 1'b1, 1'b0, acc2 + 1);
      push_s(16'h0555, 1'b0, 1'b1, acc2 + 2);
      drain();

      // Base address at top of memory wraps to 0.
      send(32'd0, 10'h3FF, acc);
      exp_addr.push_back(10'h3FF); exp_addr.push_back(10'h000); exp_addr.push_back(10'h001);
      push_s(16'h0F01, 1'b1, 1'b0, acc + 1);
      push_s(16'h0F02, 1'b0, 1'b0, acc + 2);
      push_s(16'h0F03, 1'b0, 1'b1, acc + 3);
      drain();

      // No last marker: forced end after MAX_LEN=4 samples.
      chk("err_len_before", 32'(err_len), 32'd0);
      send(32'd0, 10'h100, acc);
      exp_addr.push_back(10'h100); exp_addr.push_back(10'h101);
      exp_addr.push_back(10'h102); exp_addr.push_back(10'h103);
      push_s(16'h0101, 1'b1, 1'b0, acc + 1);
      push_s(16'h0102, 1'b0, 1'b0, acc + 2);
      push_s(16'h0103, 1'b0, 1'b0, acc + 3);
      push_s(16'h0104, 1'b0, 1'b1, acc + 4);
      repeat (5) @(negedge clk);
      chk("err_len_on_last", 32'(err_len), 32'd0);
      @(negedge clk);
      chk("err_len_set", 32'(err_len), 32'd1);
      @(posedge clk); #1;
      drain();

      // Flush on the 2nd PLAY cycle of a 5-word pulse.
      send(32'd0, 10'h200, acc);
      exp_addr.push_back(10'h200); exp_addr.push_back(10'h201);
      push_s(16'h0201, 1'b1, 1'b0, acc + 1);
      repeat (2) @(posedge clk);
      #1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_no_sample", 32'({sample_valid, mem_ren, pulse_start, pulse_done}), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_desc_ready", 32'(desc_ready), 32'd1);
      chk("flush_err_len_kept", 32'(err_len), 32'd1);
      // flush in IDLE blocks acceptance.
      @(posedge clk); #1;
      desc_addr = 10'h030; desc_delay = 32'd0;
      flush = 1'b1; desc_valid = 1'b1;
      @(negedge clk);
      chk("idle_flush_ready", 32'(desc_ready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; desc_valid = 1'b0;
      @(negedge clk);
      chk("idle_flush_no_accept", 32'(busy), 32'd0);
      @(posedge clk); #1;
      drain();

      // Reset asserted mid-WAIT returns outputs immediately.
      send(32'd100, 10'h010, acc);
      repeat (3) @(posedge clk);
      #1;
      chk("mid_wait_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_ready", 32'(desc_ready), 32'd1);
      chk("async_rst_err_len", 32'(err_len), 32'd0);
      chk("async_rst_outputs", 32'({sample_valid, pulse_start, pulse_done, mem_ren}), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Recovery after reset.
      send(32'd0, 10'h030, acc);
      exp_addr.push_back(10'h030);
      push_s(16'h0333, 1'b1, 1'b1, acc + 1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
